// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - op encodings carried on the ID/EX EX-control bus
//   - FSM state encoding
//   - default operand width and matching iteration-counter width
package ex_muldiv_unit_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bus between the EX stage / hazard logic and the multiply/divide unit.
//   master (EX stage): start, op, rs_data, rt_data, hi_rd, lo_rd, hi_we,
//                      lo_we, abort  ->  unit
//   slave  (unit)    : hi, lo, busy, done, stall  ->  EX stage / hazard logic
interface ex_muldiv_unit_if
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_rd;
    logic             lo_rd;
    logic             hi_we;
    logic             lo_we;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, rs_data, rt_data, hi_rd, lo_rd, hi_we, lo_we, abort,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_rd, lo_rd, hi_we, lo_we, abort,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/ex_muldiv_unit_muldiv_iter_core.sv
// One-step-per-cycle unsigned multiply / restoring-divide datapath.
//   i_load : capture i_a (multiplier/dividend) and i_b (multiplicand/divisor)
//   i_step : perform one iteration (i_div selects divide, else multiply)
//   o_acc  : upper half (product high word / remainder)
//   o_q    : lower half (product low word / quotient)
// After WIDTH steps {o_acc,o_q} is the product or {remainder,quotient}.
module muldiv_iter_core
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;

    // Multiply: conditional add, then shift {carry,acc,q} right by one.
    logic [WIDTH:0]   w_sum;
    // Divide: shift {acc,q} left by one, subtract divisor if it fits.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_sum   = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_m}) : {1'b0, r_acc};
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});
    // When w_ge holds the true difference is below 2^WIDTH, so truncation is exact.
    assign w_sub   = w_shift[WIDTH-1:0] - r_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_q   <= i_a;
            r_m   <= i_b;
        end else if (i_step) begin
            if (i_div) begin
                r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_ge};
            end else begin
                r_acc <= w_sum[WIDTH:1];
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    assign o_acc = r_acc;
    assign o_q   = r_q;
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of ex_muldiv_unit_if (requests in; hi/lo/busy/done/stall out)
// Flow: IDLE captures |operands| and sign info, CALC runs WIDTH iterations in
// the core, FIX applies sign correction and writes HI/LO.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ex_muldiv_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;

    logic               w_signed;
    logic               w_div;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic               w_load;
    logic               w_step;
    logic [WIDTH-1:0]   w_acc;
    logic [WIDTH-1:0]   w_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign w_rs_neg = w_signed & bus.rs_data[WIDTH-1];
    assign w_rt_neg = w_signed & bus.rt_data[WIDTH-1];
    assign w_abs_rs = w_rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    assign w_abs_rt = w_rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

    assign w_load = (r_state == ST_IDLE) & bus.start & ~bus.abort;
    assign w_step = (r_state == ST_CALC) & ~bus.abort;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_div  (r_is_div),
        .i_a    (w_abs_rs),
        .i_b    (w_abs_rt),
        .o_acc  (w_acc),
        .o_q    (w_q)
    );

    // The overflow case (-2^(W-1) / -1) falls out naturally: |q| = 2^(W-1), sign positive.
    assign w_prod     = {w_acc, w_q};
    assign w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quot     = r_neg_res ? (~w_q + 1'b1)    : w_q;
    assign w_rem      = r_neg_rem ? (~w_acc + 1'b1)  : w_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state    <= ST_CALC;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_dividend <= bus.rs_data;
                        r_is_div   <= w_div;
                        r_neg_res  <= w_rs_neg ^ w_rt_neg;
                        r_neg_rem  <= w_div & w_rs_neg;
                        r_div_zero <= w_div & (bus.rt_data == '0);
                    end else begin
                        if (bus.hi_we) r_hi <= bus.rs_data;
                        if (bus.lo_we) r_lo <= bus.rs_data;
                    end
                end
                ST_CALC: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.abort) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            if (r_div_zero) begin
                                r_hi <= r_dividend;
                                r_lo <= '1;
                            end else begin
                                r_hi <= w_rem;
                                r_lo <= w_quot;
                            end
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = r_busy & (bus.start | bus.hi_rd | bus.lo_rd | bus.hi_we | bus.lo_we);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural reference: returns {HI, LO}.
    function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sa, sb;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation and follow it to completion.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int busy_cnt;
        bit seen;
        exp = model(op, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            else seen = 1'b1;
        end
        check({tag, " completes"}, 64'(seen), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [63:0] exp_a, exp_b;
        int  stall_bad, done_cnt;
        bit  seen;
        op_e rop;
        logic [31:0] ra, rb;

        n_total = 0;
        n_pass  = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = OP_MULT; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_rd = 1'b0; bus.lo_rd = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.abort = 1'b0;

        // Reset state
        #1;
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst stall", 64'(bus.stall), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed operations
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         "mult_neg3x7");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7by2");
        run_op(OP_DIVU,  32'd100,       32'd7,         "divu_100by7");
        run_op(OP_DIVU,  32'd5,         32'd0,         "divu_by0");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         "div_by0");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

        // Randomised operations
        for (int k = 0; k < 30; k++) begin
            rop = op_e'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op(rop, ra, rb, $sformatf("rand%0d", k));
        end

        // MFHI one cycle after a MULT start waits for the product
        exp_a = model(OP_MULT, 32'h0012_3456, 32'hFFFF_8001);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_data = 32'h0012_3456; bus.rt_data = 32'hFFFF_8001;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.hi_rd = 1'b1;
        stall_bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                if (bus.stall !== 1'b1) stall_bad++;
            end else seen = 1'b1;
        end
        check("mfhi completes", 64'(seen), 64'd1);
        check("mfhi stall_while_busy", 64'(stall_bad), 64'd0);
        check("mfhi stall_released", 64'(bus.stall), 64'd0);
        check("mfhi hi", 64'(bus.hi), 64'(exp_a[63:32]));
        bus.hi_rd = 1'b0;

        // MTLO, then MTHI+MTLO together, in IDLE
        @(negedge clk);
        bus.lo_we = 1'b1; bus.rs_data = 32'h0000_1234;
        #1 check("mtlo stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1 bus.lo_we = 1'b0;
        check("mtlo lo", 64'(bus.lo), 64'h1234);
        check("mtlo hi_kept", 64'(bus.hi), 64'(exp_a[63:32]));
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.rs_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1 begin bus.hi_we = 1'b0; bus.lo_we = 1'b0; end
        check("mthilo hi", 64'(bus.hi), 64'hCAFE_F00D);
        check("mthilo lo", 64'(bus.lo), 64'hCAFE_F00D);

        // Back-to-back MULTs: the second is held by stall, then accepted
        exp_a = model(OP_MULT, 32'd1000, 32'hFFFF_FF00);
        exp_b = model(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_data = 32'd1000; bus.rt_data = 32'hFFFF_FF00;
        @(posedge clk);
        #1 begin bus.rs_data = 32'h7FFF_FFFF; bus.rt_data = 32'h7FFF_FFFF; end
        stall_bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                if (bus.stall !== 1'b1) stall_bad++;
            end else seen = 1'b1;
        end
        check("b2b first_completes", 64'(seen), 64'd1);
        check("b2b stall_held", 64'(stall_bad), 64'd0);
        check("b2b first_hilo", {bus.hi, bus.lo}, exp_a);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("b2b second_started", 64'(bus.busy), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!bus.busy) seen = 1'b1;
        end
        check("b2b second_completes", 64'(seen), 64'd1);
        check("b2b second_done", 64'(bus.done), 64'd1);
        check("b2b second_hilo", {bus.hi, bus.lo}, exp_b);

        // Abort on cycle 10 of a DIV
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.rs_data = 32'd12345; bus.rt_data = 32'd67;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy_before", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort hilo_kept", {bus.hi, bus.lo}, exp_b);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort no_done", 64'(done_cnt), 64'd0);
        check("abort hilo_after", {bus.hi, bus.lo}, exp_b);

        // Abort in IDLE blocks start
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd9; bus.rt_data = 32'd3;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.abort = 1'b0; end
        check("abort_idle busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of an operation
        run_op(OP_MULTU, 32'h0001_0000, 32'h0003_0005, "pre_reset");
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_data = 32'd77; bus.rt_data = 32'd88;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset hi", 64'(bus.hi), 64'd0);
        check("midreset lo", 64'(bus.lo), 64'd0);
        check("midreset busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(OP_DIVU, 32'd1000, 32'd33, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
